md_sequencer: RTL



---
 rtl/md_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: computes on issue, holds the result for MULT_CYCLES/DIV_CYCLES, then commits.
// Latency N cycles busy after start; no backpressure beyond stall = d_md_use & (start | busy).
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_skip;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_zero;
  logic               div_ovf;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_skip;

  assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u   = {32'd0, a} * {32'd0, b};
  assign div_zero = (b == 32'd0);
  // The one signed quotient that does not fit in 32 bits is pinned explicitly.
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (!div_zero) begin
      quo_u = a / b;
      rem_u = a % b;
      if (div_ovf) begin
        quo_s = 32'sh8000_0000;
        rem_s = '0;
      end else begin
        quo_s = $signed(a) / $signed(b);
        rem_s = $signed(a) % $signed(b);
      end
    end
  end

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    res_skip = 1'b0;
    case (op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_hi   = rem_s;
        res_lo   = quo_s;
        res_skip = div_zero;
      end
      OP_DIVU: begin
        res_hi   = rem_u;
        res_lo   = quo_u;
        res_skip = div_zero;
      end
      default: begin
        res_hi   = '0;
        res_lo   = '0;
        res_skip = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      p_skip <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p_hi   <= res_hi;
            p_lo   <= res_lo;
            p_skip <= res_skip;
            cnt    <= op[1] ? DIV_LOAD : MULT_LOAD;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        RUN: begin
          // start/mthi/mtlo are deliberately ignored while the resource is busy.
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            if (!p_skip) begin
              hi <= p_hi;
              lo <= p_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign stall = d_md_use & (start | busy);

endmodule
